// File: rtl/addr_router_pkg.sv
// Shared definitions for the address router: FSM state encoding, error codes
// and width helpers used by the decoder and the router top.
package addr_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_DECODE  = 2'd1,
        ERR_CMD     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A zero timeout still needs a one-bit counter to keep the ports legal.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/addr_router_match.sv
// Combinational region decoder: finds the lowest-index slave whose masked base
// matches the address and produces the slave-relative offset.
module addr_match
    import addr_router_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int N_SLAVES   = 4,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    localparam int SEL_W = sel_width(N_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_hit,
    output logic [SEL_W-1:0]      o_sel,
    output logic [ADDR_WIDTH-1:0] o_offset
);

    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] w_mask;

    // Scanning downwards lets the lowest matching index overwrite the rest.
    always_comb begin
        o_hit    = 1'b0;
        o_sel    = '0;
        o_offset = i_addr;
        w_base   = '0;
        w_mask   = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            w_base = SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_mask = SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
            if ((i_addr & w_mask) == (w_base & w_mask)) begin
                o_hit    = 1'b1;
                o_sel    = SEL_W'(i);
                o_offset = i_addr & ~w_mask;
            end
        end
    end

endmodule

// File: rtl/addr_router.sv
// N-slave address router: decodes a CPU access, strobes one slave until it
// answers or times out, then returns a single registered response pulse.
module addr_router
    import addr_router_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int N_SLAVES   = 4,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          m_addr,
    input  logic [DATA_WIDTH-1:0]          m_wdata,
    input  logic                           m_read,
    input  logic                           m_write,
    output logic [DATA_WIDTH-1:0]          m_rdata,
    output logic                           m_ready,
    output logic                           m_err,
    output logic [ADDR_WIDTH-1:0]          s_addr,
    output logic [DATA_WIDTH-1:0]          s_wdata,
    output logic [N_SLAVES-1:0]            s_read,
    output logic [N_SLAVES-1:0]            s_write,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]            s_ready
);

    localparam int SEL_W = sel_width(N_SLAVES);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SEL_W-1:0]        r_sel;
    logic                    r_write;
    logic [CNT_W-1:0]        r_cnt;
    logic [ADDR_WIDTH-1:0]   r_s_addr;
    logic [DATA_WIDTH-1:0]   r_s_wdata;
    logic [N_SLAVES-1:0]     r_s_read;
    logic [N_SLAVES-1:0]     r_s_write;
    logic                    r_m_ready;
    logic                    r_m_err;
    logic [DATA_WIDTH-1:0]   r_m_rdata;

    logic                    w_hit;
    logic [SEL_W-1:0]        w_sel;
    logic [ADDR_WIDTH-1:0]   w_offset;
    logic [N_SLAVES-1:0]     w_onehot;
    logic                    w_single;
    logic                    w_both;
    logic                    w_sel_ready;
    logic [DATA_WIDTH-1:0]   w_sel_rdata;
    logic                    w_timeout;
    logic                    w_latch;
    logic                    w_rsp_nxt;
    err_code_t               w_err_code;
    logic [DATA_WIDTH-1:0]   w_rdata_nxt;
    logic [N_SLAVES-1:0]     w_s_read_nxt;
    logic [N_SLAVES-1:0]     w_s_write_nxt;

    addr_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N_SLAVES   (N_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_match (
        .i_addr   (m_addr),
        .o_hit    (w_hit),
        .o_sel    (w_sel),
        .o_offset (w_offset)
    );

    assign w_single    = m_read ^ m_write;
    assign w_both      = m_read & m_write;
    assign w_sel_ready = s_ready[r_sel];
    assign w_sel_rdata = s_rdata[r_sel*DATA_WIDTH +: DATA_WIDTH];
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            w_onehot[i] = (w_sel == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_both || (w_single && !w_hit)) w_state_nxt = ST_RESP;
                else if (w_single)                  w_state_nxt = ST_BUSY;
            end
            ST_BUSY: if (w_sel_ready || w_timeout) w_state_nxt = ST_RESP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs; a slave answer wins over a
    // timeout landing on the same cycle.
    always_comb begin
        w_latch       = 1'b0;
        w_rsp_nxt     = 1'b0;
        w_err_code    = ERR_NONE;
        w_rdata_nxt   = '0;
        w_s_read_nxt  = r_s_read;
        w_s_write_nxt = r_s_write;
        case (r_state)
            ST_IDLE: begin
                w_s_read_nxt  = '0;
                w_s_write_nxt = '0;
                if (w_both) begin
                    w_rsp_nxt  = 1'b1;
                    w_err_code = ERR_CMD;
                end else if (w_single) begin
                    w_latch = 1'b1;
                    if (!w_hit) begin
                        w_rsp_nxt  = 1'b1;
                        w_err_code = ERR_DECODE;
                    end else if (m_read) begin
                        w_s_read_nxt = w_onehot;
                    end else begin
                        w_s_write_nxt = w_onehot;
                    end
                end
            end
            ST_BUSY: begin
                if (w_sel_ready) begin
                    w_s_read_nxt  = '0;
                    w_s_write_nxt = '0;
                    w_rsp_nxt     = 1'b1;
                    if (!r_write) w_rdata_nxt = w_sel_rdata;
                end else if (w_timeout) begin
                    w_s_read_nxt  = '0;
                    w_s_write_nxt = '0;
                    w_rsp_nxt     = 1'b1;
                    w_err_code    = ERR_TIMEOUT;
                end
            end
            default: begin
                w_s_read_nxt  = '0;
                w_s_write_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel     <= '0;
            r_write   <= 1'b0;
            r_cnt     <= '0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_read  <= '0;
            r_s_write <= '0;
            r_m_ready <= 1'b0;
            r_m_err   <= 1'b0;
            r_m_rdata <= '0;
        end else begin
            if (w_latch) begin
                r_sel     <= w_sel;
                r_write   <= m_write;
                r_s_addr  <= w_offset;
                r_s_wdata <= m_wdata;
            end
            if (r_state != ST_BUSY)    r_cnt <= '0;
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            r_s_read  <= w_s_read_nxt;
            r_s_write <= w_s_write_nxt;
            r_m_ready <= w_rsp_nxt;
            r_m_err   <= (w_err_code != ERR_NONE);
            r_m_rdata <= w_rdata_nxt;
        end
    end

    assign m_rdata = r_m_rdata;
    assign m_ready = r_m_ready;
    assign m_err   = r_m_err;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
    assign s_read  = r_s_read;
    assign s_write = r_s_write;

endmodule

// File: tb/tb_addr_router.sv
// Self-checking bench for addr_router: directed scenarios plus randomized
// transactions scored against a region-table reference model.
module tb_addr_router;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 15;
    localparam logic [NS*AW-1:0] BASE_F = {32'h4000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASK_F = {32'hF000_0000, 32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_wdata;
    logic           m_read;
    logic           m_write;
    logic [DW-1:0]  m_rdata;
    logic           m_ready;
    logic           m_err;
    logic [AW-1:0]  s_addr;
    logic [DW-1:0]  s_wdata;
    logic [NS-1:0]  s_read;
    logic [NS-1:0]  s_write;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0]  s_ready;

    logic [31:0] words [NS];
    logic [31:0] ref_base [NS] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h4000_0000};
    logic [31:0] ref_mask [NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000, 32'hF000_0000};

    int n_tests = 0;
    int n_fail  = 0;

    int          ob_rdy, ob_rdy_cnt, ob_rd_first, ob_rd_last, ob_wr_first, ob_wr_last;
    logic        ob_err, ob_unstable, ob_seen_strobe;
    logic [31:0] ob_rdata, ob_saddr, ob_swdata;
    logic [3:0]  ob_rd_mask, ob_wr_mask;

    always #5 clk = ~clk;

    assign s_rdata = {words[3], words[2], words[1], words[0]};

    addr_router #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_SLAVES   (NS),
        .SLAVE_BASE (BASE_F),
        .SLAVE_MASK (MASK_F),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_read  (m_read),
        .m_write (m_write),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_read  (s_read),
        .s_write (s_write),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    function automatic void ref_decode(input logic [31:0] a, output logic hit,
                                       output int idx, output logic [31:0] off);
        hit = 1'b0;
        idx = 0;
        off = a;
        for (int i = 0; i < NS; i++) begin
            if (!hit && ((a & ref_mask[i]) == (ref_base[i] & ref_mask[i]))) begin
                hit = 1'b1;
                idx = i;
                off = a & ~ref_mask[i];
            end
        end
    endfunction

    // Drives one request from a negedge (cycle 0) and records what the router
    // does; the responding slave answers at cycle lat (0 = never), and the
    // other slaves toggle their ready randomly.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic rd, input logic wr, input int lat);
        logic [3:0] strobe;
        ob_rdy = -1; ob_rdy_cnt = 0;
        ob_rd_first = -1; ob_rd_last = -1; ob_wr_first = -1; ob_wr_last = -1;
        ob_err = 1'b0; ob_unstable = 1'b0; ob_seen_strobe = 1'b0;
        ob_rdata = '0; ob_saddr = '0; ob_swdata = '0;
        ob_rd_mask = '0; ob_wr_mask = '0;
        m_addr = addr; m_wdata = wdata; m_read = rd; m_write = wr;
        for (int c = 1; c <= TO + 3; c++) begin
            @(negedge clk);
            strobe = s_read | s_write;
            if (s_read != 0) begin
                if (ob_rd_first < 0) ob_rd_first = c;
                ob_rd_last = c;
                ob_rd_mask = ob_rd_mask | s_read;
            end
            if (s_write != 0) begin
                if (ob_wr_first < 0) ob_wr_first = c;
                ob_wr_last = c;
                ob_wr_mask = ob_wr_mask | s_write;
            end
            if (strobe != 0) begin
                if (!ob_seen_strobe) begin
                    ob_seen_strobe = 1'b1;
                    ob_saddr  = s_addr;
                    ob_swdata = s_wdata;
                end else if (s_addr !== ob_saddr || s_wdata !== ob_swdata) begin
                    ob_unstable = 1'b1;
                end
            end
            if (m_ready) begin
                ob_rdy_cnt++;
                if (ob_rdy < 0) begin
                    ob_rdy = c; ob_err = m_err; ob_rdata = m_rdata;
                    m_read = 1'b0; m_write = 1'b0;
                end
            end
            s_ready = (4'($urandom) & ~strobe) | ((c == lat) ? strobe : 4'h0);
            if (ob_rdy >= 0 && c > ob_rdy) break;
        end
        s_ready = '0; m_read = 1'b0; m_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_addr = 32'h0001_0000; m_wdata = 32'hFFFF_FFFF;
        m_read = 1'b1; m_write = 1'b0; s_ready = '1;
        repeat (3) @(negedge clk);
        n_tests++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL reset.m_ready got %0b want 0", m_ready); end
        n_tests++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL reset.m_err got %0b want 0", m_err); end
        n_tests++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL reset.m_rdata got %h want 0", m_rdata); end
        n_tests++; if (s_read !== 4'h0 || s_write !== 4'h0) begin n_fail++; $display("FAIL reset.strobes got %b/%b want 0/0", s_read, s_write); end
        n_tests++; if (s_addr !== 32'h0 || s_wdata !== 32'h0) begin n_fail++; $display("FAIL reset.s_bus got %h/%h want 0/0", s_addr, s_wdata); end
        m_read = 1'b0; s_ready = '0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_hit();
        words = '{32'h1111_1111, 32'hDEAD_BEEF, 32'h3333_3333, 32'h4444_4444};
        run_txn(32'h0001_0024, 32'h0, 1'b1, 1'b0, 3);
        n_tests++; if (ob_rdy !== 4) begin n_fail++; $display("FAIL read_hit.ready_cycle got %0d want 4", ob_rdy); end
        n_tests++; if (ob_rd_mask !== 4'b0010 || ob_wr_mask !== 4'b0000) begin n_fail++; $display("FAIL read_hit.strobe got %b/%b want 0010/0000", ob_rd_mask, ob_wr_mask); end
        n_tests++; if (ob_rd_first !== 1 || ob_rd_last !== 3) begin n_fail++; $display("FAIL read_hit.window got %0d..%0d want 1..3", ob_rd_first, ob_rd_last); end
        n_tests++; if (ob_saddr !== 32'h24 || ob_unstable) begin n_fail++; $display("FAIL read_hit.s_addr got %h (unstable=%0b) want 24", ob_saddr, ob_unstable); end
        n_tests++; if (ob_rdata !== 32'hDEAD_BEEF || ob_err !== 1'b0) begin n_fail++; $display("FAIL read_hit.resp got %h err=%0b want deadbeef err=0", ob_rdata, ob_err); end
        n_tests++; if (ob_rdy_cnt !== 1) begin n_fail++; $display("FAIL read_hit.pulses got %0d want 1", ob_rdy_cnt); end
    endtask

    task automatic test_write();
        words = '{32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003};
        run_txn(32'h0000_0010, 32'h1234_5678, 1'b0, 1'b1, 1);
        n_tests++; if (ob_rdy !== 2) begin n_fail++; $display("FAIL write.ready_cycle got %0d want 2", ob_rdy); end
        n_tests++; if (ob_wr_mask !== 4'b0001 || ob_wr_first !== 1 || ob_wr_last !== 1) begin n_fail++; $display("FAIL write.strobe got %b cycles %0d..%0d want 0001 1..1", ob_wr_mask, ob_wr_first, ob_wr_last); end
        n_tests++; if (ob_swdata !== 32'h1234_5678 || ob_saddr !== 32'h10) begin n_fail++; $display("FAIL write.s_bus got %h/%h want 10/12345678", ob_saddr, ob_swdata); end
        n_tests++; if (ob_err !== 1'b0 || ob_rdata !== 32'h0) begin n_fail++; $display("FAIL write.resp got %h err=%0b want 0 err=0", ob_rdata, ob_err); end
    endtask

    task automatic test_miss();
        words = '{32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
        run_txn(32'h8000_0000, 32'h0, 1'b1, 1'b0, 1);
        n_tests++; if (ob_rdy !== 1 || ob_err !== 1'b1) begin n_fail++; $display("FAIL miss.resp got cycle %0d err=%0b want cycle 1 err=1", ob_rdy, ob_err); end
        n_tests++; if (ob_rd_mask !== 4'b0 || ob_wr_mask !== 4'b0) begin n_fail++; $display("FAIL miss.strobe got %b/%b want 0/0", ob_rd_mask, ob_wr_mask); end
        n_tests++; if (ob_rdata !== 32'h0) begin n_fail++; $display("FAIL miss.rdata got %h want 0", ob_rdata); end
    endtask

    task automatic test_timeout();
        run_txn(32'h0001_0000, 32'h0, 1'b1, 1'b0, 0);
        n_tests++; if (ob_rd_first !== 1 || ob_rd_last !== TO) begin n_fail++; $display("FAIL timeout.window got %0d..%0d want 1..%0d", ob_rd_first, ob_rd_last, TO); end
        n_tests++; if (ob_rdy !== TO + 1 || ob_err !== 1'b1) begin n_fail++; $display("FAIL timeout.resp got cycle %0d err=%0b want cycle %0d err=1", ob_rdy, ob_err, TO + 1); end
        n_tests++; if (ob_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout.rdata got %h want 0", ob_rdata); end
    endtask

    task automatic test_overlap();
        words = '{32'hC0C0_0000, 32'hC1C1_0001, 32'hC2C2_0002, 32'hC3C3_0003};
        run_txn(32'h0000_0010, 32'h0, 1'b1, 1'b0, 2);
        n_tests++; if (ob_rd_mask !== 4'b0001) begin n_fail++; $display("FAIL overlap.low_wins got %b want 0001", ob_rd_mask); end
        n_tests++; if (ob_rdata !== 32'hC0C0_0000 || ob_rdy !== 3) begin n_fail++; $display("FAIL overlap.resp got %h cycle %0d want c0c00000 cycle 3", ob_rdata, ob_rdy); end
        run_txn(32'h0020_0008, 32'h0, 1'b1, 1'b0, 1);
        n_tests++; if (ob_rd_mask !== 4'b0100 || ob_saddr !== 32'h0020_0008) begin n_fail++; $display("FAIL overlap.slave2 got %b addr %h want 0100 addr 00200008", ob_rd_mask, ob_saddr); end
    endtask

    task automatic test_both();
        run_txn(32'h0001_0000, 32'h9999_9999, 1'b1, 1'b1, 1);
        n_tests++; if (ob_rdy !== 1 || ob_err !== 1'b1) begin n_fail++; $display("FAIL both.resp got cycle %0d err=%0b want cycle 1 err=1", ob_rdy, ob_err); end
        n_tests++; if (ob_rd_mask !== 4'b0 || ob_wr_mask !== 4'b0) begin n_fail++; $display("FAIL both.strobe got %b/%b want 0/0", ob_rd_mask, ob_wr_mask); end
    endtask

    task automatic test_rst_busy();
        logic seen;
        m_addr = 32'h0001_0004; m_wdata = '0; m_read = 1'b1; m_write = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (s_read !== 4'b0010) begin n_fail++; $display("FAIL rst_busy.pre got %b want 0010", s_read); end
        rst = 1'b1; m_read = 1'b0;
        @(negedge clk);
        n_tests++; if (s_read !== 4'b0 || s_write !== 4'b0 || m_ready !== 1'b0) begin n_fail++; $display("FAIL rst_busy.abort got %b/%b rdy=%0b want 0/0 rdy=0", s_read, s_write, m_ready); end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | m_ready;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_busy.no_resp got %0b want 0", seen); end
        run_txn(32'h4000_0100, 32'hCAFE_F00D, 1'b0, 1'b1, 2);
        n_tests++; if (ob_rdy !== 3 || ob_err !== 1'b0 || ob_wr_mask !== 4'b1000) begin n_fail++; $display("FAIL rst_busy.next got cycle %0d err=%0b mask %b want 3 0 1000", ob_rdy, ob_err, ob_wr_mask); end
        n_tests++; if (ob_saddr !== 32'h0000_0100 || ob_swdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rst_busy.s_bus got %h/%h want 00000100/cafef00d", ob_saddr, ob_swdata); end
    endtask

    // Back-to-back random traffic: each request starts in the idle cycle
    // right after the previous response.
    task automatic test_random();
        logic [31:0] a, wd, exp_off, exp_rdata;
        logic        rd, wr, hit, exp_err, ok_path;
        int          idx, lat, kind, exp_rdy;
        logic [3:0]  exp_rmask, exp_wmask;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: a = {16'h0000, 16'($urandom)};
                1: a = {16'h0001, 16'($urandom)};
                2: a = {8'h00, 24'($urandom)};
                3: a = {4'h4, 28'($urandom)};
                default: a = $urandom;
            endcase
            wd = $urandom;
            for (int i = 0; i < NS; i++) words[i] = $urandom;
            case ($urandom_range(0, 9))
                0: begin rd = 1'b1; wr = 1'b1; end
                1, 2, 3, 4: begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b0; end
            endcase
            lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);

            ref_decode(a, hit, idx, exp_off);
            ok_path   = hit && !(rd && wr);
            exp_rmask = (ok_path && rd) ? 4'(1 << idx) : 4'h0;
            exp_wmask = (ok_path && wr) ? 4'(1 << idx) : 4'h0;
            if (!ok_path)      begin exp_rdy = 1;       exp_err = 1'b1; end
            else if (lat == 0) begin exp_rdy = TO + 1;  exp_err = 1'b1; end
            else               begin exp_rdy = lat + 1; exp_err = 1'b0; end
            exp_rdata = (ok_path && rd && lat != 0) ? words[idx] : 32'h0;

            run_txn(a, wd, rd, wr, lat);
            n_tests++; if (ob_rdy !== exp_rdy || ob_rdy_cnt !== 1) begin n_fail++; $display("FAIL rand[%0d].ready a=%h got cycle %0d x%0d want cycle %0d x1", t, a, ob_rdy, ob_rdy_cnt, exp_rdy); end
            n_tests++; if (ob_err !== exp_err) begin n_fail++; $display("FAIL rand[%0d].err a=%h got %0b want %0b", t, a, ob_err, exp_err); end
            n_tests++; if (ob_rdata !== exp_rdata) begin n_fail++; $display("FAIL rand[%0d].rdata a=%h got %h want %h", t, a, ob_rdata, exp_rdata); end
            n_tests++; if (ob_rd_mask !== exp_rmask || ob_wr_mask !== exp_wmask) begin n_fail++; $display("FAIL rand[%0d].strobe a=%h got %b/%b want %b/%b", t, a, ob_rd_mask, ob_wr_mask, exp_rmask, exp_wmask); end
            if (ok_path) begin
                n_tests++; if (ob_saddr !== exp_off || ob_unstable) begin n_fail++; $display("FAIL rand[%0d].s_addr got %h (unstable=%0b) want %h", t, ob_saddr, ob_unstable, exp_off); end
                n_tests++; if (ob_rd_first + ob_wr_first + 1 !== 1 || ob_rd_last + ob_wr_last + 1 !== exp_rdy - 1) begin n_fail++; $display("FAIL rand[%0d].window got rd %0d..%0d wr %0d..%0d want 1..%0d", t, ob_rd_first, ob_rd_last, ob_wr_first, ob_wr_last, exp_rdy - 1); end
                if (wr) begin
                    n_tests++; if (ob_swdata !== wd) begin n_fail++; $display("FAIL rand[%0d].s_wdata got %h want %h", t, ob_swdata, wd); end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; m_addr = '0; m_wdata = '0; m_read = 1'b0; m_write = 1'b0; s_ready = '0;
        for (int i = 0; i < NS; i++) words[i] = '0;
        @(negedge clk);
        test_reset();
        test_read_hit();
        test_write();
        test_miss();
        test_timeout();
        test_overlap();
        test_both();
        test_rst_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
